pll_phase_filter: RTL and testbench
===================================

// Module: pll_phase_filter
// PURPOSE
//  Upstream stage of the NCO: digital phase detector plus PI loop filter.
//  - Measures the time, in clk cycles, between rising edges of an external reference and the NCO feedback clock.
//  - Filters that error into the signed trim word `ctrl` that drives the NCO.
//  - Flags lock once the error stays small for long enough.
// PARAMETERS
//  CTRL_W    24    width of signed ctrl output (matches NCO CTRL_W)
//  ERR_W     12    width of signed phase error; |err| saturates at 2^(ERR_W-1)-1
//  KP_SH     6     proportional gain = err <<< KP_SH
//  KI_SH     2     integral gain = err <<< KI_SH per update
//  LOCK_TOL  4     |err| <= LOCK_TOL counts as in-lock
//  LOCK_CNT  16    consecutive in-lock updates needed to assert locked
// PORTS
//  clk         in   1       system clock
//  rst         in   1       asynchronous, active-high reset
//  ena         in   1       enable; low = freeze filter, abort measurement
//  ref_in      in   1       reference clock, asynchronous to clk
//  fb_in       in   1       NCO clk_out, synchronous to clk
//  clr_integ   in   1       synchronous integrator clear (1-cycle pulse)
//  ctrl        out  CTRL_W  signed trim word to NCO
//  ctrl_valid  out  1       1-cycle pulse when ctrl updates
//  phase_err   out  ERR_W   signed last measured error (debug)
//  locked      out  1       lock indicator
// BEHAVIOUR
//  Reset: ctrl=0, ctrl_valid=0, phase_err=0, locked=0, integ=0, lock_cnt=0, FSM=IDLE.
//  Input conditioning:
//   - ref_in passes a 2-FF synchronizer, then a rising-edge detector (ref_rise).
//   - fb_in uses a 1-FF rising-edge detector (fb_rise).
//  FSM states: IDLE, REF_FIRST, FB_FIRST, UPDATE.
//   - IDLE:
//     - ref_rise & fb_rise in the same cycle -> err=0, go to UPDATE.
//     - ref_rise only -> cnt=1, go to REF_FIRST.
//     - fb_rise only -> cnt=1, go to FB_FIRST.
//   - REF_FIRST (reference leads, NCO slow):
//     - fb_rise -> err=+cnt, go to UPDATE.
//     - otherwise cnt++.
//     - cnt reaches 2^(ERR_W-1)-1 -> err=+max, go to UPDATE (timeout).
//     - a repeated ref_rise is ignored.
//   - FB_FIRST: mirror of REF_FIRST with err=-cnt (NCO fast).
//   - UPDATE: one cycle, performs the filter step below, then returns to IDLE.
//     - Edges arriving during UPDATE are dropped.
//  Filter step (internal width CTRL_W+2, sign-extended err):
//   - integ_n = sat(integ + (err <<< KI_SH))
//   - ctrl    = sat(integ_n + (err <<< KP_SH))
//   - sat clamps to [-2^(CTRL_W-1), 2^(CTRL_W-1)-1]
//   - integ <= integ_n
//   - phase_err <= err
//   - ctrl_valid <= 1 for exactly one cycle
//  Latency: the closing edge is seen on ref_rise/fb_rise in cycle t; FSM is in UPDATE in t+1; ctrl, phase_err and ctrl_valid are visible in t+2.
//  Lock:
//   - On each update: |err| <= LOCK_TOL -> lock_cnt++ (saturates at LOCK_CNT); else lock_cnt=0 and locked=0.
//   - locked=1 when lock_cnt reaches LOCK_CNT.
//  clr_integ:
//   - integ=0, lock_cnt=0, locked=0; ctrl is unchanged until the next update.
//   - If it coincides with UPDATE, the clear wins: integ=0 and ctrl=sat(err <<< KP_SH).
//  ena low:
//   - FSM returns to IDLE and cnt is cleared.
//   - integ, ctrl and locked hold; ctrl_valid=0.
//   - Edge detectors keep running, so no false edge appears when ena rises.
//  Reset mid-measurement: immediate return to reset values; the partial count is discarded.
// STRUCTURE
//  pll_pkg:
//   - pd_state_t enum (IDLE, REF_FIRST, FB_FIRST, UPDATE)
//   - sat_signed() function (width-generic via parameters)
//   - LOCK constants defaults
//  Sub-module edge_sync (SYNC_STAGES param: 2 for ref_in, 0 for fb_in): synchronizer plus rising-edge pulse.
// TESTING
//  1. Reset with ref/fb idle -> ctrl=0, ctrl_valid=0, locked=0; held for 100 cycles.
//  2. ref rise, fb rise 10 cycles later (KP_SH=6, KI_SH=2) -> phase_err=+10, integ=40, ctrl=680, one ctrl_valid pulse 2 cycles after the fb edge.
//  3. fb rise 3 cycles before ref (from reset) -> phase_err=-3, ctrl=-204.
//  4. Simultaneous ref/fb edges for 16 periods -> phase_err=0 each time; locked rises on the 16th ctrl_valid; then an err=20 update clears locked.
//  5. ref edges with no fb for 3000 cycles -> timeout err=+2047 per update; repeated updates drive ctrl to exactly 8388607 and hold there, no wrap.
//  6. Assert rst mid-REF_FIRST (cnt=5), and separately drop ena for 50 cycles -> rst gives reset values immediately; ena low gives no ctrl_valid and ctrl held, with the next measurement valid after ena returns.

Source files
------------

// File: rtl/pll_phase_filter_pkg.sv
// Shared types and helpers for the PLL phase detector / PI loop filter.
//  - pd_state_t : phase-detector FSM states
//  - *_DEF      : default parameter values for pll_phase_filter
//  - sat_signed : clamp a signed value to the range of a narrower signed word
package pll_phase_filter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REF_FIRST = 2'd1,
        FB_FIRST  = 2'd2,
        UPDATE    = 2'd3
    } pd_state_t;

    localparam int CTRL_W_DEF   = 24;
    localparam int ERR_W_DEF    = 12;
    localparam int KP_SH_DEF    = 6;
    localparam int KI_SH_DEF    = 2;
    localparam int LOCK_TOL_DEF = 4;
    localparam int LOCK_CNT_DEF = 16;

    // Reference path needs two flops to tame metastability; fb is already
    // in the clk domain.
    localparam int REF_SYNC_STAGES = 2;
    localparam int FB_SYNC_STAGES  = 0;

    localparam int SAT_W = 64;

    // Clamp v into [-2^(w-1), 2^(w-1)-1]. Callers sign-extend into SAT_W
    // bits and truncate the result back to w bits.
    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] v,
        input int                      w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/pll_phase_filter_edge_sync.sv
// Optional N-flop synchronizer followed by a rising-edge detector.
//  clk  : system clock
//  rst  : asynchronous active-high reset
//  d    : input level (asynchronous when SYNC_STAGES > 0)
//  rise : one-cycle pulse on each rising edge of the (synchronized) level
// With SYNC_STAGES = 0 the input is assumed to be clk-synchronous and only
// the edge-history flop is used, so rise follows d combinationally.
module pll_phase_filter_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic sync_s;
    logic prev_r;

    generate
        if (SYNC_STAGES == 0) begin : g_direct
            assign sync_s = d;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_r;

            // Synchronizer shift chain
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_r <= '0;
                end else begin
                    sync_r[0] <= d;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_r[i] <= sync_r[i-1];
                    end
                end
            end

            assign sync_s = sync_r[SYNC_STAGES-1];
        end
    endgenerate

    // Previous-level history for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= sync_s;
        end
    end

    assign rise = sync_s & ~prev_r;

endmodule

// File: rtl/pll_phase_filter.sv
// Digital phase detector plus PI loop filter feeding the NCO trim word.
//  clk        : system clock
//  rst        : asynchronous active-high reset
//  ena        : enable; low freezes the filter and aborts a measurement
//  ref_in     : reference clock (asynchronous to clk)
//  fb_in      : NCO feedback clock (synchronous to clk)
//  clr_integ  : one-cycle integrator / lock clear
//  ctrl       : signed trim word to the NCO
//  ctrl_valid : one-cycle pulse when ctrl is updated
//  phase_err  : last measured signed phase error in clk cycles
//  locked     : error has stayed within tolerance for LOCK_CNT updates
// A positive error means the reference edge came first (NCO slow).
module pll_phase_filter
    import pll_phase_filter_pkg::*;
#(
    parameter int CTRL_W   = CTRL_W_DEF,
    parameter int ERR_W    = ERR_W_DEF,
    parameter int KP_SH    = KP_SH_DEF,
    parameter int KI_SH    = KI_SH_DEF,
    parameter int LOCK_TOL = LOCK_TOL_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ena,
    input  logic                     ref_in,
    input  logic                     fb_in,
    input  logic                     clr_integ,
    output logic signed [CTRL_W-1:0] ctrl,
    output logic                     ctrl_valid,
    output logic signed [ERR_W-1:0]  phase_err,
    output logic                     locked
);

    localparam int CNT_W = ERR_W - 1;
    localparam int IW    = CTRL_W + 2;
    localparam int LCW   = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0]        CNT_MAX    = {CNT_W{1'b1}};
    localparam logic signed [ERR_W-1:0] ERR_MAX    = {1'b0, {CNT_W{1'b1}}};
    localparam logic [LCW-1:0]          LOCK_CNT_V = LCW'(LOCK_CNT);

    logic ref_rise_s;
    logic fb_rise_s;

    pd_state_t               state_r, state_s;
    logic [CNT_W-1:0]        cnt_r, cnt_s;
    logic signed [ERR_W-1:0] err_r, err_s;
    logic signed [ERR_W-1:0] cnt_ext_s;

    logic signed [IW-1:0]     err_ext_s;
    logic signed [IW-1:0]     integ_sum_s;
    logic signed [IW-1:0]     ctrl_sum_s;
    logic signed [CTRL_W-1:0] integ_n_s;
    logic signed [CTRL_W-1:0] integ_base_s;
    logic signed [CTRL_W-1:0] ctrl_n_s;
    logic                     in_lock_s;
    logic [LCW-1:0]           lock_cnt_n_s;

    logic signed [CTRL_W-1:0] integ_r;
    logic signed [CTRL_W-1:0] ctrl_r;
    logic                     ctrl_valid_r;
    logic signed [ERR_W-1:0]  phase_err_r;
    logic [LCW-1:0]           lock_cnt_r;
    logic                     locked_r;

    pll_phase_filter_edge_sync #(.SYNC_STAGES(REF_SYNC_STAGES)) u_ref_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (ref_in),
        .rise (ref_rise_s)
    );

    pll_phase_filter_edge_sync #(.SYNC_STAGES(FB_SYNC_STAGES)) u_fb_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (fb_in),
        .rise (fb_rise_s)
    );

    assign cnt_ext_s = {1'b0, cnt_r};

    // Phase-detector state, counter and measured-error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            err_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            err_r   <= err_s;
        end
    end

    // Phase-detector next state: count from the first edge to the other one
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        err_s   = err_r;
        if (!ena) begin
            state_s = IDLE;
            cnt_s   = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ref_rise_s && fb_rise_s) begin
                        err_s   = '0;
                        state_s = UPDATE;
                    end else if (ref_rise_s) begin
                        cnt_s   = CNT_W'(1);
                        state_s = REF_FIRST;
                    end else if (fb_rise_s) begin
                        cnt_s   = CNT_W'(1);
                        state_s = FB_FIRST;
                    end else begin
                        state_s = IDLE;
                    end
                end
                REF_FIRST: begin
                    // Further ref edges are ignored until fb closes the window.
                    if (fb_rise_s) begin
                        err_s   = cnt_ext_s;
                        state_s = UPDATE;
                    end else if (cnt_r == CNT_MAX) begin
                        err_s   = ERR_MAX;
                        state_s = UPDATE;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                FB_FIRST: begin
                    if (ref_rise_s) begin
                        err_s   = -cnt_ext_s;
                        state_s = UPDATE;
                    end else if (cnt_r == CNT_MAX) begin
                        err_s   = -ERR_MAX;
                        state_s = UPDATE;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                UPDATE: begin
                    // Edges arriving now are dropped on purpose.
                    cnt_s   = '0;
                    state_s = IDLE;
                end
                default: begin
                    cnt_s   = '0;
                    state_s = IDLE;
                end
            endcase
        end
    end

    // PI filter arithmetic; a coincident clear replaces the integrator by zero
    always_comb begin
        err_ext_s    = {{(IW-ERR_W){err_r[ERR_W-1]}}, err_r};
        integ_sum_s  = {{2{integ_r[CTRL_W-1]}}, integ_r} + (err_ext_s <<< KI_SH);
        integ_n_s    = CTRL_W'(sat_signed(SAT_W'(integ_sum_s), CTRL_W));
        if (clr_integ) begin
            integ_base_s = '0;
        end else begin
            integ_base_s = integ_n_s;
        end
        ctrl_sum_s   = {{2{integ_base_s[CTRL_W-1]}}, integ_base_s} + (err_ext_s <<< KP_SH);
        ctrl_n_s     = CTRL_W'(sat_signed(SAT_W'(ctrl_sum_s), CTRL_W));
        in_lock_s    = (int'(err_r) <= LOCK_TOL) && (int'(err_r) >= -LOCK_TOL);
        if (lock_cnt_r == LOCK_CNT_V) begin
            lock_cnt_n_s = lock_cnt_r;
        end else begin
            lock_cnt_n_s = lock_cnt_r + LCW'(1);
        end
    end

    // Filter state, outputs and lock tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            integ_r      <= '0;
            ctrl_r       <= '0;
            ctrl_valid_r <= 1'b0;
            phase_err_r  <= '0;
            lock_cnt_r   <= '0;
            locked_r     <= 1'b0;
        end else begin
            ctrl_valid_r <= 1'b0;
            if (ena && (state_r == UPDATE)) begin
                integ_r      <= integ_base_s;
                ctrl_r       <= ctrl_n_s;
                phase_err_r  <= err_r;
                ctrl_valid_r <= 1'b1;
                if (clr_integ || !in_lock_s) begin
                    lock_cnt_r <= '0;
                    locked_r   <= 1'b0;
                end else begin
                    lock_cnt_r <= lock_cnt_n_s;
                    locked_r   <= (lock_cnt_n_s == LOCK_CNT_V);
                end
            end else if (clr_integ) begin
                integ_r    <= '0;
                lock_cnt_r <= '0;
                locked_r   <= 1'b0;
            end else begin
                integ_r <= integ_r;
            end
        end
    end

    assign ctrl       = ctrl_r;
    assign ctrl_valid = ctrl_valid_r;
    assign phase_err  = phase_err_r;
    assign locked     = locked_r;

endmodule

// File: tb/tb_pll_phase_filter.sv
// Directed bench for pll_phase_filter. A second instance with large gains
// shares the stimulus and is used to reach ctrl saturation quickly.
// Inputs are driven and outputs sampled on the falling clock edge.
// Timing used throughout: fb_in driven at a falling edge is seen as fb_rise
// in that same cycle; ref_in is seen two cycles later (2-flop synchronizer).
module tb_pll_phase_filter;

    logic clk = 1'b0;
    logic rst;
    logic ena;
    logic ref_in;
    logic fb_in;
    logic clr_integ;

    logic signed [23:0] ctrl;
    logic               ctrl_valid;
    logic signed [11:0] phase_err;
    logic               locked;

    logic signed [23:0] sat_ctrl;
    logic               sat_ctrl_valid;
    logic signed [11:0] sat_phase_err;
    logic               sat_locked;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pll_phase_filter dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .ref_in     (ref_in),
        .fb_in      (fb_in),
        .clr_integ  (clr_integ),
        .ctrl       (ctrl),
        .ctrl_valid (ctrl_valid),
        .phase_err  (phase_err),
        .locked     (locked)
    );

    pll_phase_filter #(.KP_SH(12), .KI_SH(12)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .ref_in     (ref_in),
        .fb_in      (fb_in),
        .clr_integ  (clr_integ),
        .ctrl       (sat_ctrl),
        .ctrl_valid (sat_ctrl_valid),
        .phase_err  (sat_phase_err),
        .locked     (sat_locked)
    );

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for the ctrl_valid pulse; a missing pulse is a failure.
    task automatic wait_valid(input int max_cycles, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (ctrl_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_valid_seen"}, seen, 1);
    endtask

    // Produce edges whose internal separation is err cycles (err >= 0:
    // reference first; err <= -2: feedback first), then wait for the update.
    task automatic measure(input int err, input string tag);
        if (err >= 0) begin
            ref_in = 1'b1;
            tick(err + 2);
            fb_in = 1'b1;
        end else begin
            fb_in = 1'b1;
            tick(-err - 2);
            ref_in = 1'b1;
        end
        wait_valid(40, tag);
    endtask

    task automatic release_edges();
        ref_in = 1'b0;
        fb_in  = 1'b0;
        tick(4);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(2);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;
        logic signed [63:0] main_exp [3];
        main_exp[0] = 139196;
        main_exp[1] = 147384;
        main_exp[2] = 155572;

        rst       = 1'b1;
        ena       = 1'b1;
        ref_in    = 1'b0;
        fb_in     = 1'b0;
        clr_integ = 1'b0;

        // 1. Reset held for 100 cycles
        @(negedge clk);
        check("rst_ctrl_start", ctrl, 0);
        check("rst_valid_start", ctrl_valid, 0);
        tick(100);
        check("rst_ctrl", ctrl, 0);
        check("rst_valid", ctrl_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_phase_err", phase_err, 0);
        rst = 1'b0;
        tick(3);

        // 2. Reference leads by 10 cycles, exact two-cycle latency
        ref_in = 1'b1;
        tick(12);
        fb_in = 1'b1;
        tick(1);
        check("t2_valid_early", ctrl_valid, 0);
        tick(1);
        check("t2_valid", ctrl_valid, 1);
        check("t2_phase_err", phase_err, 10);
        check("t2_ctrl", ctrl, 680);
        tick(1);
        check("t2_valid_single", ctrl_valid, 0);
        release_edges();

        // 3. Feedback leads by 3 cycles from reset
        pulse_reset();
        measure(-3, "t3");
        check("t3_phase_err", phase_err, -3);
        check("t3_ctrl", ctrl, -204);
        release_edges();

        // 4. Aligned edges drive lock, then a large error drops it
        pulse_reset();
        for (int i = 0; i < 16; i++) begin
            measure(0, "t4");
            check("t4_phase_err", phase_err, 0);
            check("t4_ctrl", ctrl, 0);
            check("t4_locked", locked, (i == 15) ? 1 : 0);
            release_edges();
        end
        measure(20, "t4_big");
        check("t4_big_phase_err", phase_err, 20);
        check("t4_big_ctrl", ctrl, 1360);
        check("t4_big_locked", locked, 0);
        release_edges();

        // 5. Reference only: timeouts at +max, high-gain copy saturates
        pulse_reset();
        for (int i = 0; i < 3; i++) begin
            ref_in = 1'b1;
            wait_valid(2100, "t5");
            check("t5_phase_err", phase_err, 2047);
            check("t5_ctrl", ctrl, main_exp[i]);
            check("t5_sat_phase_err", sat_phase_err, 2047);
            check("t5_sat_ctrl", sat_ctrl, 8388607);
            release_edges();
        end

        // 6a. Reset in the middle of a measurement
        pulse_reset();
        measure(10, "t6_pre");
        check("t6_pre_ctrl", ctrl, 680);
        release_edges();
        ref_in = 1'b1;
        tick(7);
        rst = 1'b1;
        #1;
        check("t6_rst_ctrl", ctrl, 0);
        check("t6_rst_phase_err", phase_err, 0);
        check("t6_rst_valid", ctrl_valid, 0);
        ref_in = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(4);
        measure(5, "t6_post");
        check("t6_post_phase_err", phase_err, 5);
        check("t6_post_ctrl", ctrl, 340);
        release_edges();

        // 6b. Enable low for 50 cycles: no updates, ctrl held, no false edge
        ena = 1'b0;
        vcount = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 5)  ref_in = 1'b1;
            if (i == 10) fb_in = 1'b1;
            if (i == 20) fb_in = 1'b0;
            @(negedge clk);
            if (ctrl_valid === 1'b1) vcount++;
        end
        check("t6_ena_valid_count", vcount, 0);
        check("t6_ena_ctrl_held", ctrl, 340);
        ena = 1'b1;
        tick(6);
        ref_in = 1'b0;
        tick(4);
        measure(3, "t6_ena_post");
        check("t6_ena_post_phase_err", phase_err, 3);
        check("t6_ena_post_ctrl", ctrl, 224);
        release_edges();

        // 7. Integrator clear: idle clear keeps ctrl; clear during update wins
        clr_integ = 1'b1;
        tick(1);
        clr_integ = 1'b0;
        check("t7_clr_ctrl_held", ctrl, 224);
        check("t7_clr_locked", locked, 0);
        ref_in = 1'b1;
        tick(12);
        fb_in = 1'b1;
        tick(1);
        clr_integ = 1'b1;
        tick(1);
        clr_integ = 1'b0;
        check("t7_coinc_valid", ctrl_valid, 1);
        check("t7_coinc_ctrl", ctrl, 640);
        release_edges();
        measure(0, "t7_after");
        check("t7_after_ctrl", ctrl, 0);
        release_edges();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
